// File: rtl/hls_rate_adapter.sv
// hls_rate_adapter: clock-enable rate adapter between clk_1 control logic and a 1/DIV-rate HLS core
module hls_rate_adapter #(
  parameter int DIV     = 2,
  parameter int W       = 21,
  parameter int NCH     = 3,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 8
) (
  input  logic             clk_1,
  input  logic             ap_rst,
  input  logic             ap_start,
  input  logic             in_vld,
  input  logic [NCH*W-1:0] in_data,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic [W-1:0]     out_data,
  output logic             out_vld,
  output logic             timeout,
  output logic [CW-1:0]    drop_cnt,
  output logic             core_ce,
  output logic             core_start,
  output logic             core_in_vld,
  output logic [NCH*W-1:0] core_in_data,
  input  logic             core_done,
  input  logic             core_ready,
  input  logic             core_out_vld,
  input  logic [W-1:0]     core_out
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t        r_state;
  logic [DW-1:0] r_div_q;
  logic [SW-1:0] r_slot;
  logic          r_start_q, r_vld_q, r_cap_vld, r_ap_ready, r_timeout;
  logic          w_req;
  logic [SW-1:0] w_slot_nx;
  assign w_req       = ap_start & ~r_start_q;
  assign w_slot_nx   = r_slot + SW'(1);
  assign core_ce     = r_div_q == DW'(DIV - 1);
  assign ap_idle     = r_state == IDLE;
  assign ap_done     = r_state == DONE;
  assign out_vld     = ap_done & r_cap_vld;
  assign core_start  = r_state == ARM;
  assign core_in_vld = core_start & r_vld_q;
  assign ap_ready    = r_ap_ready;
  assign timeout     = r_timeout;
  // free-running divider; the core only advances on its last count
  always_ff @(posedge clk_1 or posedge ap_rst)
    if (ap_rst) r_div_q <= '0;
    else r_div_q <= core_ce ? '0 : r_div_q + DW'(1);
  // previous ap_start level for rising-edge detection
  always_ff @(posedge clk_1 or posedge ap_rst)
    if (ap_rst) r_start_q <= 1'b0;
    else r_start_q <= ap_start;
  // request sequencing: latch, hand to core on a ce slot, wait for result or give up
  always_ff @(posedge clk_1 or posedge ap_rst)
    if (ap_rst) begin
      r_state      <= IDLE;
      r_slot       <= '0;
      r_vld_q      <= 1'b0;
      r_cap_vld    <= 1'b0;
      r_ap_ready   <= 1'b0;
      r_timeout    <= 1'b0;
      core_in_data <= '0;
      out_data     <= '0;
    end else begin
      r_ap_ready <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: if (w_req) begin
          core_in_data <= in_data;
          r_vld_q      <= in_vld;
          r_ap_ready   <= 1'b1;
          r_state      <= ARM;
        end
        ARM: if (core_ce && core_ready) begin
          r_slot  <= '0;
          r_state <= RUN;
        end
        RUN: if (core_ce) begin
          r_slot <= w_slot_nx;
          if (core_done) begin
            if (core_out_vld) out_data <= core_out;
            r_cap_vld <= core_out_vld;
            r_state   <= DONE;
          end else if (w_slot_nx == SW'(TIMEOUT)) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  // requests arriving while busy are counted, never lost silently
  always_ff @(posedge clk_1 or posedge ap_rst)
    if (ap_rst) drop_cnt <= '0;
    else if (w_req && r_state != IDLE && drop_cnt != '1) drop_cnt <= drop_cnt + CW'(1);
endmodule

// File: tb/tb_hls_rate_adapter.sv
// tb_hls_rate_adapter: directed plus randomized checks of hls_rate_adapter against a transaction-level model
module tb_hls_rate_adapter;
  localparam int DIV = 3, W = 21, NCH = 3, TO = 4, CW = 8, DWD = NCH * W;
  logic clk_1 = 1'b0, ap_rst = 1'b1;
  always #5 clk_1 = ~clk_1;
  logic ap_start, in_vld, ap_done, ap_idle, ap_ready, out_vld, timeout;
  logic core_ce, core_start, core_in_vld, core_done, core_ready, core_out_vld;
  logic [DWD-1:0] in_data, core_in_data;
  logic [W-1:0] out_data, core_out;
  logic [CW-1:0] drop_cnt;
  logic ap_start1, in_vld1, ap_done1, ap_idle1, ap_ready1, out_vld1, timeout1;
  logic core_ce1, core_start1, core_in_vld1, core_done1, core_ready1, core_out_vld1;
  logic [DWD-1:0] in_data1, core_in_data1;
  logic [W-1:0] out_data1, core_out1;
  logic [CW-1:0] drop_cnt1;
  hls_rate_adapter #(.DIV(DIV), .W(W), .NCH(NCH), .TIMEOUT(TO), .CW(CW)) u0 (
    .clk_1(clk_1), .ap_rst(ap_rst), .ap_start(ap_start), .in_vld(in_vld), .in_data(in_data),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready), .out_data(out_data), .out_vld(out_vld),
    .timeout(timeout), .drop_cnt(drop_cnt), .core_ce(core_ce), .core_start(core_start),
    .core_in_vld(core_in_vld), .core_in_data(core_in_data), .core_done(core_done),
    .core_ready(core_ready), .core_out_vld(core_out_vld), .core_out(core_out));
  hls_rate_adapter #(.DIV(1), .W(W), .NCH(NCH), .TIMEOUT(16), .CW(CW)) u1 (
    .clk_1(clk_1), .ap_rst(ap_rst), .ap_start(ap_start1), .in_vld(in_vld1), .in_data(in_data1),
    .ap_done(ap_done1), .ap_idle(ap_idle1), .ap_ready(ap_ready1), .out_data(out_data1), .out_vld(out_vld1),
    .timeout(timeout1), .drop_cnt(drop_cnt1), .core_ce(core_ce1), .core_start(core_start1),
    .core_in_vld(core_in_vld1), .core_in_data(core_in_data1), .core_done(core_done1),
    .core_ready(core_ready1), .core_out_vld(core_out_vld1), .core_out(core_out1));
  // core function shared by the emulated cores and the reference model
  function automatic logic [W-1:0] f(input logic [DWD-1:0] d);
    return W'(d[W-1:0] + 3 * d[2*W-1:W] + 5 * d[3*W-1:2*W] + 7);
  endfunction
  function automatic logic [DWD-1:0] rd();
    return DWD'({$urandom, $urandom});
  endfunction
  // emulated HLS cores: cyc counts clk_1 edges since reset, so ce cycles are cyc % DIV == DIV-1
  int cyc = 0, done_cyc = -1, done1 = -1, lat = 3, lat1 = 2, rdy_from = 0;
  logic [W-1:0] c_res = '0, c1_res = '0;
  logic c_vld = 1'b0, m_ce;
  logic [1:0] noise = '0;
  assign m_ce = (cyc % DIV) == DIV - 1;
  assign core_ready = m_ce ? (cyc >= rdy_from) : noise[0];
  assign core_done = m_ce ? (cyc == done_cyc) : noise[1];
  assign core_out = c_res;
  assign core_out_vld = c_vld;
  assign core_ready1 = 1'b1;
  assign core_done1 = cyc == done1;
  assign core_out1 = c1_res;
  assign core_out_vld1 = 1'b1;
  assign in_vld1 = 1'b1;
  always @(posedge clk_1 or posedge ap_rst)
    if (ap_rst) begin
      cyc <= 0; done_cyc <= -1; noise <= '0;
    end else begin
      cyc <= cyc + 1;
      noise <= 2'($urandom);
      if (m_ce && core_start && core_ready) begin
        done_cyc <= cyc + lat * DIV;
        c_res <= f(core_in_data);
        c_vld <= core_in_vld;
      end
    end
  always @(posedge clk_1 or posedge ap_rst)
    if (ap_rst) done1 <= -1;
    else if (core_start1) begin
      done1 <= cyc + lat1;
      c1_res <= f(core_in_data1);
    end
  // reference model: absolute cycle windows derived per accepted request
  int n_chk = 0, n_fail = 0;
  int e_ready, e_done, e_to, s_lo, s_hi, b_lo, b_hi, e1_lo, e1_done;
  logic [W-1:0] e_out, e_new, e1_out, e1_new;
  logic [DWD-1:0] e_cdata, e1_cdata;
  logic [CW-1:0] e_drop;
  logic e_vld, prev, prev1;
  task automatic model_reset();
    e_ready = -1; e_done = -1; e_to = -1; s_lo = 1; s_hi = 0; b_lo = 1; b_hi = 0;
    e1_lo = -1; e1_done = -1; e_out = '0; e_new = '0; e1_out = '0; e1_new = '0;
    e_cdata = '0; e1_cdata = '0; e_drop = '0; e_vld = 1'b0; prev = 1'b0; prev1 = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got %0h exp %0h", tag, cyc, o, e);
    end
  endtask
  function automatic logic win(input int lo, input int hi);
    return cyc >= lo && cyc <= hi;
  endfunction
  task automatic check_all();
    chk("ce", core_ce, m_ce);
    chk("ready", ap_ready, cyc == e_ready);
    chk("start", core_start, win(s_lo, s_hi));
    chk("in_vld", core_in_vld, win(s_lo, s_hi) && e_vld);
    chk("done", ap_done, cyc == e_done);
    chk("out_vld", out_vld, cyc == e_done && e_vld);
    chk("timeout", timeout, cyc == e_to);
    chk("idle", ap_idle, !win(b_lo, b_hi));
    chk("out_data", out_data, e_out);
    chk("drop", drop_cnt, e_drop);
    chk("cdata", core_in_data, e_cdata);
    chk("ce1", core_ce1, 1'b1);
    chk("ready1", ap_ready1, cyc == e1_lo);
    chk("start1", core_start1, cyc == e1_lo);
    chk("in_vld1", core_in_vld1, cyc == e1_lo);
    chk("done1", ap_done1, cyc == e1_done);
    chk("out_vld1", out_vld1, cyc == e1_done);
    chk("idle1", ap_idle1, !win(e1_lo, e1_done));
    chk("out1", out_data1, e1_out);
    chk("cdata1", core_in_data1, e1_cdata);
    chk("to1", timeout1, 1'b0);
    chk("drop1", drop_cnt1, 0);
  endtask
  task automatic tick();
    @(posedge clk_1);
    #1;
    if (cyc == e_done && e_vld) e_out = e_new;
    if (cyc == e1_done) e1_out = e1_new;
    check_all();
  endtask
  task automatic edge0(input logic v, input logic [DWD-1:0] d);
    int a;
    if (win(b_lo, b_hi)) begin
      if (e_drop != '1) e_drop = e_drop + 1'b1;
    end else begin
      a = cyc + 1;
      while (a % DIV != DIV - 1 || a < rdy_from) a++;
      e_cdata = d; e_vld = v; e_ready = cyc + 1; s_lo = cyc + 1; s_hi = a; b_lo = cyc + 1;
      e_new = v ? f(d) : e_out;
      e_done = lat <= TO ? a + lat * DIV + 1 : -1;
      e_to = lat <= TO ? -1 : a + TO * DIV + 1;
      b_hi = lat <= TO ? e_done : e_to - 1;
    end
  endtask
  task automatic drive(input logic s, input logic v, input logic [DWD-1:0] d, input logic s1);
    logic [DWD-1:0] d1;
    d1 = rd();
    ap_start = s; in_vld = v; in_data = d; ap_start1 = s1; in_data1 = d1;
    if (s && !prev) edge0(v, d);
    if (s1 && !prev1) begin
      e1_lo = cyc + 1; e1_done = cyc + lat1 + 2; e1_new = f(d1); e1_cdata = d1;
    end
    prev = s; prev1 = s1;
    tick();
  endtask
  task automatic idle();
    drive(1'b0, 1'($urandom), rd(), 1'b0);
  endtask
  initial begin
    model_reset();
    ap_start = 1'b0; in_vld = 1'b0; in_data = '0; ap_start1 = 1'b0; in_data1 = '0;
    #12 check_all();
    #10 ap_rst = 1'b0;
    repeat (10) idle();
    drive(1'b1, 1'b1, {21'd3, 21'd2, 21'd1}, 1'b0);
    repeat (25) idle();
    chk("basic_out", out_data, 29);
    chk("basic_cdata", core_in_data, {21'd3, 21'd2, 21'd1});
    lat = 2;
    repeat (50) drive(1'b1, 1'b1, rd(), 1'b0);
    repeat (20) idle();
    lat = 4;
    drive(1'b1, 1'b1, rd(), 1'b0);
    repeat (5) idle();
    drive(1'b1, 1'b0, rd(), 1'b0);
    repeat (25) idle();
    chk("drop_run", drop_cnt, 1);
    lat = 1000;
    rdy_from = cyc + 8;
    drive(1'b1, 1'b1, rd(), 1'b0);
    repeat (30) idle();
    chk("to_idle", ap_idle, 1'b1);
    lat = 5;
    drive(1'b1, 1'b1, rd(), 1'b0);
    repeat (8) idle();
    #2 ap_rst = 1'b1;
    ap_start = 1'b0;
    #1 model_reset();
    check_all();
    #2 ap_rst = 1'b0;
    lat = 2;
    repeat (3) idle();
    drive(1'b1, 1'b1, rd(), 1'b0);
    repeat (15) idle();
    for (int i = 0; i < 40; i++) begin
      while (cyc <= b_hi) idle();
      lat = $urandom_range(1, TO + 1);
      rdy_from = cyc + $urandom_range(0, 6);
      repeat ($urandom_range(1, 4)) drive(1'b1, 1'($urandom), rd(), 1'b0);
      repeat ($urandom_range(1, 12)) idle();
      if ($urandom_range(0, 1) == 1) drive(1'b1, 1'($urandom), rd(), 1'b0);
      idle();
    end
    while (cyc <= b_hi) idle();
    lat = TO + 1;
    for (int i = 0; i < 1000; i++) drive(i % 2 == 0, 1'($urandom), rd(), 1'b0);
    repeat (30) idle();
    chk("sat", drop_cnt, 255);
    for (int i = 0; i < 6; i++) begin
      lat1 = $urandom_range(1, 6);
      drive(1'b0, 1'b0, rd(), 1'b1);
      repeat (12) idle();
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
